mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (MIPS core / host) single-port memory arbiter.
// Combinational grant with round-robin on contention, a host ownership lock,
// routing of one-cycle-latency read data back to the requester that issued
// the read, and a saturating counter of cycles in which the core was stalled.
module mem_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             core_req,
  input  logic             core_we,
  input  logic [WIDTH-1:0] core_adr,
  input  logic [WIDTH-1:0] core_wdata,
  output logic             core_gnt,
  output logic             core_rvalid,
  output logic [WIDTH-1:0] core_rdata,
  input  logic             host_req,
  input  logic             host_we,
  input  logic             host_lock,
  input  logic [WIDTH-1:0] host_adr,
  input  logic [WIDTH-1:0] host_wdata,
  output logic             host_gnt,
  output logic             host_rvalid,
  output logic [WIDTH-1:0] host_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [7:0]       core_stall_cnt
);

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_HOST = 1'b1;
  localparam logic [7:0] STALL_MAX = 8'd255;

  logic       lock_r;       // host holds ownership of the memory
  logic       ptr_r;        // round-robin owner for the next contended cycle
  logic       rd_pend_r;    // a read was granted last cycle
  logic       rd_owner_r;   // who issued that read
  logic [7:0] stall_cnt_r;

  logic       core_gnt_s;
  logic       host_gnt_s;
  logic       contended_s;
  logic       lock_s;
  logic       rd_issue_s;
  logic       core_rvalid_s;
  logic       host_rvalid_s;

  // Grant decision: reset blocks everything, lock favours host, otherwise
  // a lone requester wins and contention is settled by the pointer.
  always_comb begin
    core_gnt_s  = 1'b0;
    host_gnt_s  = 1'b0;
    contended_s = 1'b0;
    if (reset) begin
      core_gnt_s = 1'b0;
      host_gnt_s = 1'b0;
    end else if (lock_r) begin
      host_gnt_s = host_req;
    end else if (core_req && host_req) begin
      contended_s = 1'b1;
      if (ptr_r == OWN_CORE) begin
        core_gnt_s = 1'b1;
      end else begin
        host_gnt_s = 1'b1;
      end
    end else begin
      core_gnt_s = core_req;
      host_gnt_s = host_req;
    end
  end

  // Lock follows host_lock: any cycle it is low releases, a locked host grant sets.
  always_comb begin
    lock_s = lock_r;
    if (!host_lock) begin
      lock_s = 1'b0;
    end else if (host_gnt_s) begin
      lock_s = 1'b1;
    end else begin
      lock_s = lock_r;
    end
  end

  // Memory-side mux from the granted requester; zero when idle.
  always_comb begin
    mem_en    = core_gnt_s | host_gnt_s;
    mem_we    = 1'b0;
    mem_adr   = {WIDTH{1'b0}};
    mem_wdata = {WIDTH{1'b0}};
    case ({core_gnt_s, host_gnt_s})
      2'b10: begin
        mem_we    = core_we;
        mem_adr   = core_adr;
        mem_wdata = core_wdata;
      end
      2'b01: begin
        mem_we    = host_we;
        mem_adr   = host_adr;
        mem_wdata = host_wdata;
      end
      default: begin
        mem_we    = 1'b0;
        mem_adr   = {WIDTH{1'b0}};
        mem_wdata = {WIDTH{1'b0}};
      end
    endcase
  end

  assign rd_issue_s = (core_gnt_s && !core_we) || (host_gnt_s && !host_we);

  // Arbitration state, outstanding-read tracking and stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_r      <= 1'b0;
      ptr_r       <= OWN_CORE;
      rd_pend_r   <= 1'b0;
      rd_owner_r  <= OWN_CORE;
      stall_cnt_r <= 8'd0;
    end else begin
      lock_r     <= lock_s;
      rd_pend_r  <= rd_issue_s;
      rd_owner_r <= host_gnt_s ? OWN_HOST : OWN_CORE;
      if (contended_s) begin
        ptr_r <= core_gnt_s ? OWN_HOST : OWN_CORE;
      end else begin
        ptr_r <= ptr_r;
      end
      if (core_req && !core_gnt_s && (stall_cnt_r != STALL_MAX)) begin
        stall_cnt_r <= stall_cnt_r + 8'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  // Read return routing; reset in the return cycle squashes the response.
  always_comb begin
    core_rvalid_s = rd_pend_r && (rd_owner_r == OWN_CORE) && !reset;
    host_rvalid_s = rd_pend_r && (rd_owner_r == OWN_HOST) && !reset;
    core_rdata    = core_rvalid_s ? mem_rdata : {WIDTH{1'b0}};
    host_rdata    = host_rvalid_s ? mem_rdata : {WIDTH{1'b0}};
  end

  assign core_gnt       = core_gnt_s;
  assign host_gnt       = host_gnt_s;
  assign core_rvalid    = core_rvalid_s;
  assign host_rvalid    = host_rvalid_s;
  assign core_stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven bench for mem_arbiter with a read-return scoreboard.
module tb_mem_arbiter;

  logic       clk;
  logic       reset;
  logic       core_req, core_we, core_gnt, core_rvalid;
  logic [7:0] core_adr, core_wdata, core_rdata;
  logic       host_req, host_we, host_lock, host_gnt, host_rvalid;
  logic [7:0] host_adr, host_wdata, host_rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_adr, mem_wdata, mem_rdata;
  logic [7:0] core_stall_cnt;

  mem_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_adr(core_adr),
    .core_wdata(core_wdata), .core_gnt(core_gnt),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_lock(host_lock),
    .host_adr(host_adr), .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .core_stall_cnt(core_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       rst;
    bit       creq, cwe;
    bit [7:0] cadr, cwd;
    bit       hreq, hwe, hlock;
    bit [7:0] hadr, hwd;
    bit [7:0] mrd;
    bit       ecg, ehg;
  } vec_t;

  typedef struct {
    int cyc;
    bit host;
  } rd_t;

  vec_t tbl[$];
  rd_t  sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   stall_m = 0;
  bit   stall_known = 1'b0;

  function automatic vec_t mk(bit rst, bit creq, bit cwe, bit [7:0] cadr, bit [7:0] cwd,
                              bit hreq, bit hwe, bit hlock, bit [7:0] hadr, bit [7:0] hwd,
                              bit [7:0] mrd, bit ecg, bit ehg);
    vec_t v;
    v.rst = rst; v.creq = creq; v.cwe = cwe; v.cadr = cadr; v.cwd = cwd;
    v.hreq = hreq; v.hwe = hwe; v.hlock = hlock; v.hadr = hadr; v.hwd = hwd;
    v.mrd = mrd; v.ecg = ecg; v.ehg = ehg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, check mid-cycle, update the model.
  task automatic step(input vec_t v);
    bit       ecv, ehv;
    bit       ewe;
    bit [7:0] eadr, ewd;
    rd_t      e;
    reset = v.rst;
    core_req = v.creq; core_we = v.cwe; core_adr = v.cadr; core_wdata = v.cwd;
    host_req = v.hreq; host_we = v.hwe; host_lock = v.hlock;
    host_adr = v.hadr; host_wdata = v.hwd;
    mem_rdata = v.mrd;
    @(negedge clk);
    chk("core_gnt", {31'd0, core_gnt}, {31'd0, v.ecg});
    chk("host_gnt", {31'd0, host_gnt}, {31'd0, v.ehg});
    ewe  = v.ecg ? v.cwe  : (v.ehg ? v.hwe  : 1'b0);
    eadr = v.ecg ? v.cadr : (v.ehg ? v.hadr : 8'h00);
    ewd  = v.ecg ? v.cwd  : (v.ehg ? v.hwd  : 8'h00);
    chk("mem_en", {31'd0, mem_en}, {31'd0, v.ecg | v.ehg});
    chk("mem_we", {31'd0, mem_we}, {31'd0, ewe});
    chk("mem_adr", {24'd0, mem_adr}, {24'd0, eadr});
    chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, ewd});
    ecv = 1'b0;
    ehv = 1'b0;
    if (v.rst) begin
      sb.delete();
    end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      if (e.host) ehv = 1'b1;
      else ecv = 1'b1;
    end
    chk("core_rvalid", {31'd0, core_rvalid}, {31'd0, ecv});
    chk("host_rvalid", {31'd0, host_rvalid}, {31'd0, ehv});
    chk("core_rdata", {24'd0, core_rdata}, {24'd0, (ecv ? v.mrd : 8'h00)});
    chk("host_rdata", {24'd0, host_rdata}, {24'd0, (ehv ? v.mrd : 8'h00)});
    if (stall_known) chk("stall_cnt", {24'd0, core_stall_cnt}, stall_m);
    if (v.rst) begin
      stall_m = 0;
      stall_known = 1'b1;
    end else if (v.creq && !v.ecg && stall_m != 255) begin
      stall_m++;
    end
    if ((v.ecg && !v.cwe) || (v.ehg && !v.hwe)) begin
      e.cyc = cyc + 1;
      e.host = v.ehg;
      sb.push_back(e);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    //            rst creq cwe cadr   cwd    hreq hwe lock hadr   hwd    mrd    ecg ehg
    // reset forces everything low even with both requesting
    tbl.push_back(mk(1, 1, 0, 8'h33, 8'h00, 1, 0, 1, 8'h44, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0));
    // lone core read, data returns next cycle
    tbl.push_back(mk(0, 1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h0D, 0, 0));
    // four contended writes: core, host, core, host
    tbl.push_back(mk(0, 1, 1, 8'h20, 8'h11, 1, 1, 0, 8'h30, 8'h22, 8'h00, 1, 0));
    tbl.push_back(mk(0, 1, 1, 8'h21, 8'h12, 1, 1, 0, 8'h31, 8'h23, 8'h00, 0, 1));
    tbl.push_back(mk(0, 1, 1, 8'h22, 8'h13, 1, 1, 0, 8'h32, 8'h24, 8'h00, 1, 0));
    tbl.push_back(mk(0, 1, 1, 8'h23, 8'h14, 1, 1, 0, 8'h33, 8'h25, 8'h00, 0, 1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0));
    // locked host write, core shut out while lock holds
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 8'hFF, 8'h0D, 8'h00, 0, 1));
    tbl.push_back(mk(0, 1, 0, 8'h40, 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h41, 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h42, 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h43, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h44, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h5A, 0, 0));
    // back-to-back reads by alternating requesters
    tbl.push_back(mk(0, 1, 0, 8'h01, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h02, 8'h00, 8'hAA, 0, 1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'hBB, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'hCC, 0, 0));
    // reset the cycle after a core read squashes the return
    tbl.push_back(mk(0, 1, 0, 8'h05, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0));
    tbl.push_back(mk(1, 1, 0, 8'h06, 8'h00, 1, 0, 0, 8'h07, 8'h00, 8'h77, 0, 0));
    tbl.push_back(mk(0, 1, 1, 8'h50, 8'h01, 1, 1, 0, 8'h60, 8'h02, 8'h00, 1, 0));
    tbl.push_back(mk(0, 1, 1, 8'h51, 8'h03, 1, 1, 0, 8'h61, 8'h04, 8'h00, 0, 1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0));

    reset = 1'b1;
    core_req = 1'b0; core_we = 1'b0; core_adr = 8'h00; core_wdata = 8'h00;
    host_req = 1'b0; host_we = 1'b0; host_lock = 1'b0;
    host_adr = 8'h00; host_wdata = 8'h00; mem_rdata = 8'h00;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Hand sequence: host takes the lock, wins contention while locked,
    // and the core stalls long enough to saturate the counter.
    step(mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h80, 8'h81, 8'h00, 0, 1));
    step(mk(0, 1, 1, 8'h82, 8'h83, 1, 1, 1, 8'h84, 8'h85, 8'h00, 0, 1));
    step(mk(0, 1, 0, 8'h86, 8'h00, 1, 0, 1, 8'h87, 8'h00, 8'h00, 0, 1));
    step(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'h99, 0, 0));
    for (int k = 0; k < 300; k++) begin
      step(mk(0, 1, 0, 8'h90, 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 0));
    end
    chk("stall_saturated", {24'd0, core_stall_cnt}, 32'd255);
    step(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0));
    step(mk(0, 1, 0, 8'h09, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0));
    step(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h3C, 0, 0));
    chk("stall_held", {24'd0, core_stall_cnt}, 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
